maze_walker: RTL
================

Name: maze_walker

Overview:
- Parametrised player-navigation core for the FPGA maze game.
- Holds the player position on a COLS x ROWS grid and accepts direction requests through a valid/ready handshake.
- Checks each request against a wall bitmap and the grid bounds, counts steps, and detects arrival at the goal cell.
- Sits between the debounced button front-end and the VGA/LED renderer; the wall bitmap comes from a maze ROM outside this block.

Parameters:
- COLS, 16, grid width in cells (>=2).
- ROWS, 12, grid height in cells (>=2).
- START_X, 0, reset/restart column.
- START_Y, 0, reset/restart row.
- GOAL_X, COLS-1, goal column.
- GOAL_Y, ROWS-1, goal row.
- STEP_W, 16, step counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset (clear when rst==0).
- start  in  1  level-sampled pulse: begin or restart a game.
- dir_valid  in  1  direction request valid.
- dir  in  2  0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1).
- dir_ready  out  1  request accepted when dir_valid && dir_ready.
- wall_map  in  COLS*ROWS  bit index y*COLS+x; 1 = wall.
- pos_x  out  $clog2(COLS)  current column.
- pos_y  out  $clog2(ROWS)  current row.
- step_cnt  out  STEP_W  successful moves this game.
- moved  out  1  one-cycle pulse, move committed.
- bump  out  1  one-cycle pulse, move rejected.
- won  out  1  high while in WON.
- playing  out  1  high while in PLAY or CHECK.

Behaviour:
- Reset (rst==0, async): state IDLE; pos=(START_X,START_Y); step_cnt=0; moved=bump=won=playing=dir_ready=0.
- IDLE:
  - dir_ready=0.
  - start=1 -> PLAY; pos=start cell; step_cnt=0.
- PLAY:
  - dir_ready=1.
  - On handshake, register dir and compute the target cell -> CHECK.
- CHECK:
  - dir_ready=0.
  - Target outside the grid (x-1 at x=0, x+1 at x=COLS-1, same for y) -> bump=1, position unchanged.
  - Target wall bit = 1 -> bump=1, position unchanged.
  - Otherwise pos<=target and moved=1.
  - step_cnt increments on a committed move and saturates at all-ones.
  - If the new pos equals (GOAL_X,GOAL_Y) -> WON, else -> PLAY.
- Latency: a handshake at edge N gives pos/moved/bump at edge N+1. Next acceptance is possible at edge N+2, so at most one request per 2 cycles.
- WON:
  - won=1, dir_ready=0, dir_valid ignored, pos and step_cnt frozen.
  - start -> PLAY with restart values.
- start has priority in every state:
  - In PLAY/CHECK it restarts: pos=start cell, step_cnt=0, state PLAY.
  - A simultaneous handshake is discarded.
  - A pending CHECK is aborted with no moved/bump pulse.
- wall_map is sampled combinationally in CHECK. Changes outside CHECK have no effect on position.
- The start cell is never wall-checked. If the start cell equals the goal cell, start enters PLAY, not WON.
- moved and bump are mutually exclusive and are registered outputs.
- Reset asserted mid-operation returns to IDLE immediately, regardless of state.

Optional Feature:
- Macro: MAZE_WRAP_EN.
- Defined: edges wrap toroidally.
  - x-1 at x=0 -> COLS-1; x+1 at COLS-1 -> 0; y wraps the same way.
  - The wrapped cell is then wall-checked normally.
  - bump only on a wall.
- Undefined: an out-of-bounds target always gives bump, as above.

Test Plan:
- COLS=ROWS=4, empty wall_map; release reset, pulse start, send right x3 then down x3 -> six moved pulses, pos=(3,3), step_cnt=6, won=1, dir_ready=0.
- From (0,0), send dir=0 (up) -> bump pulse, pos stays (0,0), step_cnt=0. With MAZE_WRAP_EN -> moved, pos=(0,3), step_cnt=1.
- Set wall bit 1 (cell (1,0)); at (0,0) send right -> bump, pos unchanged; then down -> moved, pos=(0,1).
- Hold dir_valid continuously with dir=right -> dir_ready alternates 1/0, one move per 2 cycles, pos_x 0->1->2->3 then bump.
- Mid-game at (2,1), assert start in the same cycle as a handshake -> no moved/bump, pos=(0,0), step_cnt=0, playing=1. In WON, send dir -> ignored.
- Pull rst low asynchronously during CHECK -> outputs at reset values before the next clk edge; state IDLE; start is required to play.

Source files
------------

// File: rtl/maze_walker.sv
// rtl/maze_walker.sv - player-navigation core for the FPGA maze game
//
// Holds the player position on a COLS x ROWS grid. It accepts one direction
// request per two cycles through a valid/ready handshake, checks the target
// cell against the grid bounds and the wall bitmap, counts committed moves
// and detects arrival at the goal cell.
//
// Build option: define MAZE_WRAP_EN to make the grid edges wrap toroidally.
// The wrapped cell is still wall-checked.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   rst        asynchronous active-low reset
//   start      begin or restart a game; has priority in every state
//   dir_valid  direction request valid
//   dir        0=up (y-1), 1=down (y+1), 2=left (x-1), 3=right (x+1)
//   dir_ready  high only in PLAY; a request is accepted on dir_valid && dir_ready
//   wall_map   one bit per cell at index y*COLS+x; 1 = wall
//   pos_x      current column
//   pos_y      current row
//   step_cnt   committed moves this game; saturates at all-ones
//   moved      registered one-cycle pulse: a move was committed
//   bump       registered one-cycle pulse: a move was rejected
//   won        high while in WON
//   playing    high while in PLAY or CHECK
module maze_walker #(
  parameter int COLS    = 16,
  parameter int ROWS    = 12,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = COLS - 1,
  parameter int GOAL_Y  = ROWS - 1,
  parameter int STEP_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     dir_valid,
  input  logic [1:0]               dir,
  output logic                     dir_ready,
  input  logic [COLS*ROWS-1:0]     wall_map,
  output logic [$clog2(COLS)-1:0]  pos_x,
  output logic [$clog2(ROWS)-1:0]  pos_y,
  output logic [STEP_W-1:0]        step_cnt,
  output logic                     moved,
  output logic                     bump,
  output logic                     won,
  output logic                     playing
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int IW = $clog2(COLS * ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    WON   = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [XW-1:0]       pos_x_d, tgt_x, tgt_x_d, nx;
  logic [YW-1:0]       pos_y_d, tgt_y, tgt_y_d, ny;
  logic [STEP_W-1:0]   step_d;
  logic                moved_d, bump_d;
  logic                oob, oob_d, n_oob, at_edge;
  logic [IW-1:0]       widx;
  logic                wall_hit;

  assign dir_ready = (state == PLAY);
  assign won       = (state == WON);
  assign playing   = (state == PLAY) || (state == CHECK);

  // Candidate target for the current position and requested direction.
  // The wrapped coordinate is always computed; whether an edge crossing is
  // a bump or a legal wrap is decided by the build option.
  always_comb begin
    nx      = pos_x;
    ny      = pos_y;
    at_edge = 1'b0;
    case (dir)
      2'd0: begin
        at_edge = (pos_y == '0);
        ny      = at_edge ? YW'(ROWS - 1) : pos_y - 1'b1;
      end
      2'd1: begin
        at_edge = (pos_y == YW'(ROWS - 1));
        ny      = at_edge ? '0 : pos_y + 1'b1;
      end
      2'd2: begin
        at_edge = (pos_x == '0);
        nx      = at_edge ? XW'(COLS - 1) : pos_x - 1'b1;
      end
      default: begin
        at_edge = (pos_x == XW'(COLS - 1));
        nx      = at_edge ? '0 : pos_x + 1'b1;
      end
    endcase
`ifdef MAZE_WRAP_EN
    n_oob = 1'b0;
`else
    n_oob = at_edge;
`endif
  end

  // The wall bitmap is only looked at while resolving a registered target.
  assign widx     = IW'(tgt_y) * IW'(COLS) + IW'(tgt_x);
  assign wall_hit = wall_map[widx];

  always_comb begin
    state_d = state;
    pos_x_d = pos_x;
    pos_y_d = pos_y;
    step_d  = step_cnt;
    tgt_x_d = tgt_x;
    tgt_y_d = tgt_y;
    oob_d   = oob;
    moved_d = 1'b0;
    bump_d  = 1'b0;
    if (start) begin
      // Restart wins over a simultaneous handshake and over a pending CHECK.
      state_d = PLAY;
      pos_x_d = XW'(START_X);
      pos_y_d = YW'(START_Y);
      step_d  = '0;
    end else begin
      case (state)
        PLAY: begin
          if (dir_valid) begin
            tgt_x_d = nx;
            tgt_y_d = ny;
            oob_d   = n_oob;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (oob || wall_hit) begin
            bump_d  = 1'b1;
            state_d = PLAY;
          end else begin
            moved_d = 1'b1;
            pos_x_d = tgt_x;
            pos_y_d = tgt_y;
            if (step_cnt != '1) step_d = step_cnt + 1'b1;
            if (tgt_x == XW'(GOAL_X) && tgt_y == YW'(GOAL_Y)) state_d = WON;
            else                                              state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pos_x    <= XW'(START_X);
      pos_y    <= YW'(START_Y);
      step_cnt <= '0;
      tgt_x    <= '0;
      tgt_y    <= '0;
      oob      <= 1'b0;
      moved    <= 1'b0;
      bump     <= 1'b0;
    end else begin
      state    <= state_d;
      pos_x    <= pos_x_d;
      pos_y    <= pos_y_d;
      step_cnt <= step_d;
      tgt_x    <= tgt_x_d;
      tgt_y    <= tgt_y_d;
      oob      <= oob_d;
      moved    <= moved_d;
      bump     <= bump_d;
    end
  end

endmodule
